// File: rtl/alu_stage_pkg.sv
// Shared types and default widths for the ALU operand stage.
package alu_stage_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int OPCODE_LENGTH_DEF  = 4;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  // One buffered operation at the default widths. The stage declares an
  // identically laid-out type sized by its own parameters.
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]     src_a;
    logic [DATA_WIDTH_DEF-1:0]     src_b;
    logic [OPCODE_LENGTH_DEF-1:0]  operation;
    logic [REG_ADDR_WIDTH_DEF-1:0] rd;
  } alu_entry_t;

endpackage

// File: rtl/operand_forward.sv
// Bypass selection for one source operand. EX/MEM wins over MEM/WB, and
// register index 0 is never forwarded because it is hard-wired to zero.
module operand_forward
  import alu_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      exmem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  logic addr_nonzero;
  logic exmem_hit;
  logic memwb_hit;

  assign addr_nonzero = (src_addr != '0);
  assign exmem_hit    = exmem_regwrite && (exmem_rd == src_addr) && addr_nonzero;
  assign memwb_hit    = memwb_regwrite && (memwb_rd == src_addr) && addr_nonzero;

  // Pick the youngest in-flight producer, falling back to the register file.
  always_comb begin
    fwd_data = rf_data;
    if (exmem_hit) begin
      fwd_data = exmem_result;
    end else if (memwb_hit) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage between decode and the ALU: resolves bypassing when an
// operation is accepted and buffers up to two operations in a skid FIFO so
// the decode handshake never depends combinationally on the ALU side.
module alu_operand_stage
  import alu_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int OPCODE_LENGTH  = OPCODE_LENGTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic                      alu_src,
  input  logic [OPCODE_LENGTH-1:0]  alu_op,
  input  logic                      exmem_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [REG_ADDR_WIDTH-1:0] rd_out
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     src_a;
    logic [DATA_WIDTH-1:0]     src_b;
    logic [OPCODE_LENGTH-1:0]  operation;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } entry_t;

  fifo_state_e state_reg, state_next;
  entry_t      head_reg, head_next;
  entry_t      tail_reg, tail_next;
  entry_t      in_entry;
  logic        push;
  logic        pop;

  // Index 0 is rs1, index 1 is rs2.
  logic [REG_ADDR_WIDTH-1:0] src_addr [2];
  logic [DATA_WIDTH-1:0]     src_rf   [2];
  logic [DATA_WIDTH-1:0]     src_fwd  [2];

  assign src_addr[0] = rs1_addr;
  assign src_addr[1] = rs2_addr;
  assign src_rf[0]   = rs1_data;
  assign src_rf[1]   = rs2_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      operand_forward #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
      ) u_fwd (
        .src_addr       (src_addr[gi]),
        .rf_data        (src_rf[gi]),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .fwd_data       (src_fwd[gi])
      );
    end
  endgenerate

  // Handshake flags come from registered state only.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Assemble the entry that would be captured this cycle.
  always_comb begin
    in_entry.src_a     = src_fwd[0];
    in_entry.src_b     = alu_src ? imm : src_fwd[1];
    in_entry.operation = alu_op;
    in_entry.rd        = rd_addr;
  end

  // Occupancy and entry movement; flush discards everything, including a
  // simultaneous push or pop.
  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush) begin
      state_next = EMPTY;
      head_next  = '0;
      tail_next  = '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_next  = in_entry;
            state_next = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_next  = in_entry;
              state_next = FULL;
            end
            2'b01: begin
              head_next  = '0;
              state_next = EMPTY;
            end
            2'b11: begin
              head_next  = in_entry;
            end
            default: begin
            end
          endcase
        end
        FULL: begin
          if (pop) begin
            head_next  = tail_reg;
            tail_next  = '0;
            state_next = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
          head_next  = '0;
          tail_next  = '0;
        end
      endcase
    end
  end

  // State and entry registers, cleared immediately when reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  // Present the head entry only while something is buffered.
  always_comb begin
    SrcA      = '0;
    SrcB      = '0;
    Operation = '0;
    rd_out    = '0;
    if (out_valid) begin
      SrcA      = head_reg.src_a;
      SrcB      = head_reg.src_b;
      Operation = head_reg.operation;
      rd_out    = head_reg.rd;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, forwarding, immediate select,
// skid-buffer back-pressure, flush and asynchronous reset.
module tb_alu_operand_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

  alu_operand_stage dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rd_addr        (rd_addr),
    .imm            (imm),
    .alu_src        (alu_src),
    .alu_op         (alu_op),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .SrcA           (SrcA),
    .SrcB           (SrcB),
    .Operation      (Operation),
    .rd_out         (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op, input logic [4:0] rd);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".SrcA"}, SrcA, a);
    check({tag, ".SrcB"}, SrcB, b);
    check({tag, ".Operation"}, {28'd0, Operation}, {28'd0, op});
    check({tag, ".rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    $display("step %s: out_valid=%0b in_ready=%0b SrcA=%0h SrcB=%0h op=%0h rd=%0d",
             tag, out_valid, in_ready, SrcA, SrcB, Operation, rd_out);
  endtask

  task automatic check_ready(input string tag, input logic r);
    check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, r});
  endtask

  // Plain entry with no bypass hits and SrcB from rs2.
  task automatic set_entry(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [4:0] rd);
    rs1_data       = a;
    rs2_data       = b;
    alu_op         = op;
    rd_addr        = rd;
    rs1_addr       = 5'd1;
    rs2_addr       = 5'd2;
    alu_src        = 1'b0;
    imm            = 32'd0;
    exmem_regwrite = 1'b0;
    exmem_rd       = 5'd0;
    exmem_result   = 32'd0;
    memwb_regwrite = 1'b0;
    memwb_rd       = 5'd0;
    memwb_result   = 32'd0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    set_entry(32'd0, 32'd0, 4'd0, 5'd0);

    // Reset held low across an edge.
    tick();
    check_out("reset", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
    check_ready("reset", 1'b1);
    reset = 1'b1;
    tick();

    // Basic push, visible the cycle after capture.
    set_entry(32'd5, 32'd7, 4'b0010, 5'd3);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    check_out("basic", 1'b1, 32'd5, 32'd7, 4'b0010, 5'd3);
    in_valid = 1'b0;
    tick();
    check_out("basic_pop", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0);

    // Forwarding: push+pop each cycle, the newest entry becomes head.
    in_valid = 1'b1;
    set_entry(32'h11, 32'h22, 4'd1, 5'd9);
    rs1_addr = 5'd4; rs2_addr = 5'd5;
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
    tick();
    check_out("fwd_exmem", 1'b1, 32'hAA, 32'h22, 4'd1, 5'd9);

    exmem_regwrite = 1'b0;
    tick();
    check_out("fwd_memwb", 1'b1, 32'hBB, 32'h22, 4'd1, 5'd9);

    rs1_addr = 5'd0; rs1_data = 32'h33;
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    tick();
    check_out("fwd_x0", 1'b1, 32'h33, 32'h22, 4'd1, 5'd9);

    set_entry(32'h44, 32'h55, 4'd3, 5'd7);
    rs2_addr = 5'd7; exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h10;
    alu_src = 1'b1; imm = 32'hFFFF_FFFC;
    tick();
    check_out("imm_sel", 1'b1, 32'h44, 32'hFFFF_FFFC, 4'd3, 5'd7);

    alu_src = 1'b0;
    tick();
    check_out("fwd_rs2", 1'b1, 32'h44, 32'h10, 4'd3, 5'd7);

    in_valid = 1'b0;
    tick();
    check_out("drain", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0);

    // Back-pressure: fill both entries, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_entry(32'hA1, 32'hA2, 4'd1, 5'd1);
    tick();
    check_out("bp_a", 1'b1, 32'hA1, 32'hA2, 4'd1, 5'd1);
    check_ready("bp_a", 1'b1);
    set_entry(32'hB1, 32'hB2, 4'd2, 5'd2);
    tick();
    check_out("bp_full", 1'b1, 32'hA1, 32'hA2, 4'd1, 5'd1);
    check_ready("bp_full", 1'b0);
    set_entry(32'hD1, 32'hD2, 4'd4, 5'd4);
    tick();
    check_out("bp_hold", 1'b1, 32'hA1, 32'hA2, 4'd1, 5'd1);
    check_ready("bp_hold", 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_out("bp_pop_a", 1'b1, 32'hB1, 32'hB2, 4'd2, 5'd2);
    check_ready("bp_pop_a", 1'b1);
    tick();
    check_out("bp_pop_b", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0);

    // Flush while FULL with a simultaneous push and pop request.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_entry(32'hA1, 32'hA2, 4'd1, 5'd1);
    tick();
    set_entry(32'hB1, 32'hB2, 4'd2, 5'd2);
    tick();
    check_ready("fl_full", 1'b0);
    set_entry(32'hC1, 32'hC2, 4'd5, 5'd5);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    check_out("flush", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
    check_ready("flush", 1'b1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_out("flush_after", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0);

    // Asynchronous reset between edges while ONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_entry(32'hE1, 32'hE2, 4'd6, 5'd6);
    tick();
    check_out("pre_rst", 1'b1, 32'hE1, 32'hE2, 4'd6, 5'd6);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0);
    check_ready("async_rst", 1'b1);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_entry(32'hF1, 32'hF2, 4'd7, 5'd8);
    tick();
    check_out("post_rst", 1'b1, 32'hF1, 32'hF2, 4'd7, 5'd8);
    in_valid = 1'b0;
    tick();
    check_out("post_rst_pop", 1'b0, 32'd0, 32'd0, 4'd0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
